// File: rtl/gw_miim_master.sv
// gw_miim_master: Clause 22 MDIO/MDC management master.
// Turns single-cycle read/write requests into 64-bit (or 32-bit with
// preamble suppression) serial frames, divides clk down to MDC and
// samples read data from the PHY through a 2-flop synchroniser.
module gw_miim_master #(
  parameter int CLK_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  miim_phyad,
  input  logic [4:0]  miim_regad,
  input  logic [15:0] miim_wrdata,
  input  logic        miim_wren,
  input  logic        miim_rden,
  output logic [15:0] miim_rddata,
  output logic        miim_rddata_valid,
  output logic        miim_busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int N  = PRE_LEN + 32;
  localparam int BW = $clog2(N);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [BW-1:0] PRE_END  = BW'(PRE_LEN);
  localparam logic [BW-1:0] HDR_END  = BW'(PRE_LEN + 14);
  localparam logic [BW-1:0] TA_END   = BW'(PRE_LEN + 16);
  localparam logic [BW-1:0] BIT_ONE  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PH_ZERO  = {PW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_TA   = 3'd3,
    ST_DATA = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic [PW-1:0]  ph_r, ph_s;
  logic           half_r, half_s;        // 0 = MDC low phase, 1 = high phase
  logic [BW-1:0]  bit_r, bit_s, bit_nx_s;
  logic           op_rd_r, op_rd_s;
  logic [31:0]    frame_r, frame_s, frame_v_s;  // post-preamble bits, MSB next
  logic [15:0]    shift_r, shift_s, shift_nx_s;
  logic           mdc_r, mdc_s;
  logic           mdio_o_r, mdio_o_s;
  logic           mdio_oe_r, mdio_oe_s;
  logic           busy_r, busy_s;
  logic [15:0]    rddata_r, rddata_s;
  logic           valid_r, valid_s;
  logic [1:0]     sync_r;
  logic           pre_done_s;

  assign miim_rddata       = rddata_r;
  assign miim_rddata_valid = valid_r;
  assign miim_busy         = busy_r;
  assign mdc               = mdc_r;
  assign mdio_o            = mdio_o_r;
  assign mdio_oe           = mdio_oe_r;
  assign shift_nx_s        = {shift_r[14:0], sync_r[1]};

  // Two-flop synchroniser for the asynchronous MDIO pad input (idles high like the pull-up)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], mdio_i};
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ph_r      <= PH_ZERO;
      half_r    <= 1'b0;
      bit_r     <= BIT_ZERO;
      op_rd_r   <= 1'b0;
      frame_r   <= 32'hFFFF_FFFF;
      shift_r   <= 16'h0000;
      mdc_r     <= 1'b0;
      mdio_o_r  <= 1'b1;
      mdio_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      rddata_r  <= 16'h0000;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      ph_r      <= ph_s;
      half_r    <= half_s;
      bit_r     <= bit_s;
      op_rd_r   <= op_rd_s;
      frame_r   <= frame_s;
      shift_r   <= shift_s;
      mdc_r     <= mdc_s;
      mdio_o_r  <= mdio_o_s;
      mdio_oe_r <= mdio_oe_s;
      busy_r    <= busy_s;
      rddata_r  <= rddata_s;
      valid_r   <= valid_s;
    end
  end

  // Next-state logic: request accept, MDC phase timing and bit sequencing
  always_comb begin
    state_s    = state_r;
    ph_s       = ph_r;
    half_s     = half_r;
    bit_s      = bit_r;
    op_rd_s    = op_rd_r;
    frame_s    = frame_r;
    shift_s    = shift_r;
    mdc_s      = mdc_r;
    mdio_o_s   = mdio_o_r;
    mdio_oe_s  = mdio_oe_r;
    busy_s     = busy_r;
    rddata_s   = rddata_r;
    valid_s    = 1'b0;
    bit_nx_s   = bit_r + BIT_ONE;
    pre_done_s = (state_r != ST_PRE) || (bit_nx_s == PRE_END);
    // Write wins when both strobes arrive together; reads release TA/DATA (all ones)
    frame_v_s  = {2'b01, (miim_wren ? 2'b01 : 2'b10), miim_phyad, miim_regad,
                  (miim_wren ? {2'b10, miim_wrdata} : 18'h3FFFF)};

    case (state_r)
      ST_IDLE: begin
        if (miim_wren || miim_rden) begin
          op_rd_s   = !miim_wren;
          busy_s    = 1'b1;
          mdc_s     = 1'b0;
          ph_s      = PH_ZERO;
          half_s    = 1'b0;
          bit_s     = BIT_ZERO;
          mdio_oe_s = 1'b1;
          if (PRE_LEN == 32'sd0) begin
            state_s  = ST_HDR;
            mdio_o_s = frame_v_s[31];
            frame_s  = {frame_v_s[30:0], 1'b1};
          end else begin
            state_s  = ST_PRE;
            mdio_o_s = 1'b1;
            frame_s  = frame_v_s;
          end
        end else begin
          mdc_s     = 1'b0;
          mdio_o_s  = 1'b1;
          mdio_oe_s = 1'b0;
          busy_s    = 1'b0;
        end
      end

      ST_PRE, ST_HDR, ST_TA, ST_DATA: begin
        if (ph_r != PH_LAST) begin
          ph_s = ph_r + PH_ONE;
        end else if (!half_r) begin
          // End of low phase: raise MDC
          ph_s   = PH_ZERO;
          half_s = 1'b1;
          mdc_s  = 1'b1;
        end else begin
          // End of high phase: sample (DATA only) and move to the next bit
          ph_s = PH_ZERO;
          if (state_r == ST_DATA) begin
            shift_s = shift_nx_s;
          end else begin
            shift_s = shift_r;
          end
          if (bit_r == LAST_BIT) begin
            state_s   = ST_IDLE;
            half_s    = 1'b0;
            bit_s     = BIT_ZERO;
            mdc_s     = 1'b0;
            mdio_o_s  = 1'b1;
            mdio_oe_s = 1'b0;
            busy_s    = 1'b0;
            if (op_rd_r) begin
              rddata_s = shift_nx_s;
              valid_s  = 1'b1;
            end else begin
              rddata_s = rddata_r;
              valid_s  = 1'b0;
            end
          end else begin
            bit_s  = bit_nx_s;
            half_s = 1'b0;
            mdc_s  = 1'b0;
            if (pre_done_s) begin
              mdio_o_s = frame_r[31];
              frame_s  = {frame_r[30:0], 1'b1};
            end else begin
              mdio_o_s = 1'b1;
              frame_s  = frame_r;
            end
            // Reads hand the bus to the PHY from the first TA bit onward
            mdio_oe_s = !op_rd_r || (bit_nx_s < HDR_END);
            if (!pre_done_s) begin
              state_s = ST_PRE;
            end else if (bit_nx_s < HDR_END) begin
              state_s = ST_HDR;
            end else if (bit_nx_s < TA_END) begin
              state_s = ST_TA;
            end else begin
              state_s = ST_DATA;
            end
          end
        end
      end

      default: begin
        state_s   = ST_IDLE;
        ph_s      = PH_ZERO;
        half_s    = 1'b0;
        bit_s     = BIT_ZERO;
        mdc_s     = 1'b0;
        mdio_o_s  = 1'b1;
        mdio_oe_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gw_miim_master.sv
// Bench for gw_miim_master: two instances (D=2/PRE=32 and D=3/PRE=0).
// Stimulus pushes expected frames into per-instance queues; a monitor
// reconstructs each frame from the pins and compares on busy fall.
module tb_gw_miim_master;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    int          nb;
    int          width;
    int          lowlen;
    bit          rd;
    logic [15:0] rddata;
    bit          b2b;
    bit          abort;
    int          fall_at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wren, rden, mdc, mdio_o, mdio_oe, mdio_in, busy, valid;
  logic [4:0]  phyad [2];
  logic [4:0]  regad [2];
  logic [15:0] wrdata [2];
  logic [15:0] rddata [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  int          pushed [2];
  int          frames_seen [2];
  logic [15:0] last_rd [2];
  logic [15:0] phy_data [2];

  gw_miim_master #(.CLK_DIV(2), .PRE_LEN(32)) dut0 (
    .clk(clk), .rst(rst),
    .miim_phyad(phyad[0]), .miim_regad(regad[0]), .miim_wrdata(wrdata[0]),
    .miim_wren(wren[0]), .miim_rden(rden[0]),
    .miim_rddata(rddata[0]), .miim_rddata_valid(valid[0]), .miim_busy(busy[0]),
    .mdc(mdc[0]), .mdio_o(mdio_o[0]), .mdio_oe(mdio_oe[0]), .mdio_i(mdio_in[0])
  );

  gw_miim_master #(.CLK_DIV(3), .PRE_LEN(0)) dut1 (
    .clk(clk), .rst(rst),
    .miim_phyad(phyad[1]), .miim_regad(regad[1]), .miim_wrdata(wrdata[1]),
    .miim_wren(wren[1]), .miim_rden(rden[1]),
    .miim_rddata(rddata[1]), .miim_rddata_valid(valid[1]), .miim_busy(busy[1]),
    .mdc(mdc[1]), .mdio_o(mdio_o[1]), .mdio_oe(mdio_oe[1]), .mdio_i(mdio_in[1])
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int div_of(input int s);
    return (s == 0) ? 2 : 3;
  endfunction

  function automatic int pre_of(input int s);
    return (s == 0) ? 32 : 0;
  endfunction

  task automatic chk(input bit ok, input string name, input int s,
                     input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s (dut%0d): got 0x%0h, required 0x%0h", name, s, act, req);
  endtask

  task automatic enqueue(input int s, input exp_t e);
    if (s == 0) q0.push_back(e);
    else q1.push_back(e);
    pushed[s]++;
  endtask

  // Build the expected frame from first principles and queue it
  task automatic push_frame(input int s, input bit rd, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] wd,
                            input logic [15:0] rdv, input bit b2b);
    exp_t        e;
    logic [13:0] hdr;
    logic [17:0] tail;
    int          p;
    p        = pre_of(s);
    e.bits   = 64'h0;
    e.oe     = 64'h0;
    e.nb     = p + 32;
    e.width  = 2 * e.nb * div_of(s);
    e.lowlen = div_of(s);
    e.rd     = rd;
    e.b2b    = b2b;
    e.abort  = 1'b0;
    e.fall_at = 0;
    for (int i = 0; i < p; i++) begin
      e.bits = {e.bits[62:0], 1'b1};
      e.oe   = {e.oe[62:0], 1'b1};
    end
    hdr  = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra};
    tail = {2'b10, wd};
    for (int i = 13; i >= 0; i--) begin
      e.bits = {e.bits[62:0], hdr[i]};
      e.oe   = {e.oe[62:0], 1'b1};
    end
    for (int i = 17; i >= 0; i--) begin
      e.bits = {e.bits[62:0], (rd ? 1'b0 : tail[i])};
      e.oe   = {e.oe[62:0], !rd};
    end
    if (rd) begin
      phy_data[s] = rdv;
      last_rd[s]  = rdv;
    end
    e.rddata = last_rd[s];
    enqueue(s, e);
  endtask

  // Drive a one-cycle request; called and returns on a negedge
  task automatic req(input int s, input bit w, input bit r, input logic [4:0] pa,
                     input logic [4:0] ra, input logic [15:0] wd);
    phyad[s]  = pa;
    regad[s]  = ra;
    wrdata[s] = wd;
    wren[s]   = w;
    rden[s]   = r;
    @(negedge clk);
    wren[s] = 1'b0;
    rden[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[s] !== 1'b0 && n < 2000);
    if (busy[s] !== 1'b0) chk(1'b0, "busy_timeout", s, {63'h0, busy[s]}, 64'h0);
  endtask

  // PHY model and frame monitor, both evaluated once per negedge
  initial begin : monitor
    bit          in_frame [2];
    logic        prev_mdc [2];
    logic        phy_prev [2];
    bit          seen_rise [2];
    logic [63:0] bits [2];
    logic [63:0] oev [2];
    int          nb [2], width [2], lowlen [2], vcnt [2], gap [2], fall_cyc [2], phy_cnt [2];
    exp_t        e;
    bit          have;
    for (int s = 0; s < 2; s++) begin
      in_frame[s] = 1'b0; prev_mdc[s] = 1'b0; phy_prev[s] = 1'b0; seen_rise[s] = 1'b0;
      bits[s] = 64'h0; oev[s] = 64'h0; nb[s] = 0; width[s] = 0; lowlen[s] = 0;
      vcnt[s] = 0; gap[s] = 0; fall_cyc[s] = -100; phy_cnt[s] = 0;
    end
    mdio_in = 2'b11;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        // PHY: present the next bit at each MDC falling edge once the bus is released
        if (busy[s] !== 1'b1) begin
          phy_cnt[s] = 0;
          mdio_in[s] = 1'b1;
        end else if (mdc[s] === 1'b0 && phy_prev[s] === 1'b1 && mdio_oe[s] === 1'b0) begin
          if (phy_cnt[s] < 2) mdio_in[s] = (phy_cnt[s] == 0) ? 1'b1 : 1'b0;
          else mdio_in[s] = phy_data[s][17 - phy_cnt[s]];
          phy_cnt[s]++;
        end
        phy_prev[s] = mdc[s];

        if (!in_frame[s]) begin
          if (busy[s] === 1'b1) begin
            in_frame[s] = 1'b1;
            gap[s] = cyc - fall_cyc[s];
            bits[s] = 64'h0; oev[s] = 64'h0; nb[s] = 0; width[s] = 0;
            lowlen[s] = 0; vcnt[s] = 0; seen_rise[s] = 1'b0; prev_mdc[s] = 1'b0;
          end else if (valid[s] === 1'b1) begin
            chk(1'b0, "stray_valid", s, 64'h1, 64'h0);
          end
        end

        if (in_frame[s]) begin
          if (busy[s] === 1'b1) begin
            width[s]++;
            if (mdc[s] === 1'b1 && prev_mdc[s] === 1'b0) begin
              bits[s] = {bits[s][62:0], mdio_o[s]};
              oev[s]  = {oev[s][62:0], mdio_oe[s]};
              nb[s]++;
              seen_rise[s] = 1'b1;
            end
            if (mdc[s] === 1'b0 && !seen_rise[s]) lowlen[s]++;
            if (valid[s] === 1'b1) vcnt[s]++;
            prev_mdc[s] = mdc[s];
          end else begin
            in_frame[s] = 1'b0;
            fall_cyc[s] = cyc;
            frames_seen[s]++;
            have = 1'b0;
            if (s == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (s == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (!have) begin
              chk(1'b0, "unexpected_frame", s, 64'(nb[s]), 64'h0);
            end else begin
              if (e.abort) begin
                chk(cyc == e.fall_at, "abort_busy_fall_cycle", s, 64'(cyc), 64'(e.fall_at));
                chk(vcnt[s] == 0 && valid[s] === 1'b0, "abort_no_valid", s,
                    64'(vcnt[s]) + {63'h0, valid[s]}, 64'h0);
              end else begin
                chk(nb[s] == e.nb, "bit_count", s, 64'(nb[s]), 64'(e.nb));
                chk((bits[s] & e.oe) == e.bits, "mdio_bits", s, bits[s] & e.oe, e.bits);
                chk(oev[s] == e.oe, "mdio_oe_per_bit", s, oev[s], e.oe);
                chk(width[s] == e.width, "busy_width", s, 64'(width[s]), 64'(e.width));
                chk(lowlen[s] == e.lowlen, "first_low_phase", s, 64'(lowlen[s]), 64'(e.lowlen));
                chk(vcnt[s] == 0 && valid[s] === e.rd, "valid_pulse", s,
                    {62'h0, (vcnt[s] != 0), valid[s]}, {63'h0, e.rd});
                if (e.b2b) chk(gap[s] == 1, "back_to_back_gap", s, 64'(gap[s]), 64'h1);
              end
              chk(rddata[s] === e.rddata, "rddata", s, {48'h0, rddata[s]}, {48'h0, e.rddata});
              chk({mdc[s], mdio_oe[s], mdio_o[s]} === 3'b001, "idle_pins", s,
                  {61'h0, mdc[s], mdio_oe[s], mdio_o[s]}, 64'h1);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    exp_t e;
    rst  = 1'b1;
    wren = 2'b00;
    rden = 2'b00;
    for (int s = 0; s < 2; s++) begin
      phyad[s] = 5'h00; regad[s] = 5'h00; wrdata[s] = 16'h0000;
      last_rd[s] = 16'h0000; phy_data[s] = 16'hFFFF;
      pushed[s] = 0; frames_seen[s] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk({mdc[s], mdio_o[s], mdio_oe[s], busy[s], valid[s]} === 5'b01000, "reset_pins", s,
          {59'h0, mdc[s], mdio_o[s], mdio_oe[s], busy[s], valid[s]}, 64'h8);
      chk(rddata[s] === 16'h0000, "reset_rddata", s, {48'h0, rddata[s]}, 64'h0);
    end

    // Write 0x1140 to PHY 1 reg 0 (D=2, 32-bit preamble)
    push_frame(0, 1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0);
    req(0, 1'b1, 1'b0, 5'h01, 5'h00, 16'h1140);
    wait_idle(0);
    repeat (3) @(negedge clk);

    // Read PHY 1 reg 1, PHY returns 0x796D
    push_frame(0, 1'b1, 5'h01, 5'h01, 16'h0000, 16'h796D, 1'b0);
    req(0, 1'b0, 1'b1, 5'h01, 5'h01, 16'h0000);
    wait_idle(0);
    repeat (3) @(negedge clk);

    // wren+rden together -> write only; a read during busy is dropped
    push_frame(0, 1'b0, 5'h02, 5'h04, 16'hA5C3, 16'h0000, 1'b0);
    req(0, 1'b1, 1'b1, 5'h02, 5'h04, 16'hA5C3);
    repeat (10) @(negedge clk);
    req(0, 1'b0, 1'b1, 5'h07, 5'h09, 16'h0000);
    wait_idle(0);
    repeat (5) @(negedge clk);

    // Preamble suppression instance: read of PHY returning 0x0000
    push_frame(1, 1'b1, 5'h03, 5'h02, 16'h0000, 16'h0000, 1'b0);
    req(1, 1'b0, 1'b1, 5'h03, 5'h02, 16'h0000);
    wait_idle(1);
    repeat (3) @(negedge clk);

    // Back-to-back writes: second request in the first busy-low cycle
    push_frame(1, 1'b0, 5'h1F, 5'h1F, 16'hBEEF, 16'h0000, 1'b0);
    req(1, 1'b1, 1'b0, 5'h1F, 5'h1F, 16'hBEEF);
    wait_idle(1);
    push_frame(1, 1'b0, 5'h00, 5'h10, 16'h0001, 16'h0000, 1'b1);
    req(1, 1'b1, 1'b0, 5'h00, 5'h10, 16'h0001);
    wait_idle(1);
    repeat (3) @(negedge clk);

    // Reset during DATA bit 3 (frame bit 51) of a read
    phy_data[0] = 16'h1234;
    req(0, 1'b0, 1'b1, 5'h01, 5'h02, 16'h0000);
    repeat (205) @(negedge clk);
    e.bits = 64'h0; e.oe = 64'h0; e.nb = 0; e.width = 0; e.lowlen = 0;
    e.rd = 1'b1; e.b2b = 1'b0; e.abort = 1'b1; e.fall_at = cyc + 1;
    e.rddata = 16'h0000;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    enqueue(0, e);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      chk(frames_seen[s] == pushed[s], "frame_count", s, 64'(frames_seen[s]), 64'(pushed[s]));
    end
    chk(q0.size() == 0 && q1.size() == 0, "queues_drained", 0,
        64'(q0.size() + q1.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
